// File: rtl/op2_pkg.sv
// Shared definitions for the operand-2 fetch stage: FSM encoding, shift-type
// codes and the ARM data-processing instruction field positions.
package op2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_RM = 2'd1,
    ST_RD_RS = 2'd2,
    ST_OUT   = 2'd3
  } op2_state_t;

  // Shift type codes, as they appear in the upper two bits of SHIFT_OP
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Instruction field positions
  localparam int I_BIT     = 25;
  localparam int RS_FLAG   = 4;
  localparam int RM_LSB    = 0;
  localparam int RM_MSB    = 3;
  localparam int RS_LSB    = 8;
  localparam int RS_MSB    = 11;
  localparam int ROT_LSB   = 8;
  localparam int ROT_MSB   = 11;
  localparam int IMM8_LSB  = 0;
  localparam int IMM8_MSB  = 7;
  localparam int SHAMT_LSB = 7;
  localparam int SHAMT_MSB = 11;
  localparam int STYP_LSB  = 5;
  localparam int STYP_MSB  = 6;

  localparam logic [3:0] R15 = 4'hF;

endpackage

// File: rtl/op2_decode.sv
// Combinational shifter-operand field extraction. The immediate-form
// Shift_Data and the immediate Shift_Num are produced for every instruction;
// the FSM overwrites them later for register-sourced operands.
module op2_decode
  import op2_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_imm_form,
  output logic [2:0]  o_shift_op,
  output logic [7:0]  o_shift_num,
  output logic [31:0] o_shift_data
);

  logic w_unused;
  assign w_unused = ^{i_inst[31:26], i_inst[24:12]};

  // Split rotate-immediate from shifted-register encodings
  always_comb begin
    o_imm_form   = i_inst[I_BIT];
    o_shift_data = {24'b0, i_inst[IMM8_MSB:IMM8_LSB]};
    if (i_inst[I_BIT]) begin
      o_shift_op  = {SH_ROR, 1'b1};
      o_shift_num = {3'b0, i_inst[ROT_MSB:ROT_LSB], 1'b0};
    end else begin
      o_shift_op  = {i_inst[STYP_MSB:STYP_LSB], i_inst[RS_FLAG]};
      o_shift_num = {3'b0, i_inst[SHAMT_MSB:SHAMT_LSB]};
    end
  end

endmodule

// File: rtl/operand2_fetch.sv
// Operand-2 preparation stage feeding the barrel shifter. Reads Rm and then,
// for register-specified shifts, Rs through a single register-file port and
// presents a registered, handshaked shifter bundle.
module operand2_fetch
  import op2_pkg::*;
#(
  parameter logic [31:0] PC_OFS_IMM = 32'd8,
  parameter logic [31:0] PC_OFS_REG = 32'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] Inst,
  input  logic [31:0] PC,
  input  logic        C_In,
  input  logic        Flush,
  output logic        R_En,
  output logic [3:0]  R_Addr,
  input  logic [31:0] R_Data,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Shift_Data,
  output logic [7:0]  Shift_Num,
  output logic [2:0]  SHIFT_OP,
  output logic        Carry_flag
);

  op2_state_t  r_state;
  logic [3:0]  r_rm;
  logic [3:0]  r_rs;
  logic        r_reg_shift;
  logic [31:0] r_pc;
  logic [31:0] r_shift_data;
  logic [7:0]  r_shift_num;
  logic [2:0]  r_shift_op;
  logic        r_carry;

  logic        w_imm_form;
  logic [2:0]  w_shift_op;
  logic [7:0]  w_shift_num;
  logic [31:0] w_shift_data;
  logic        w_accept;
  logic [31:0] w_rm_val;
  logic [31:0] w_rs_val;

  op2_decode u_decode (
    .i_inst       (Inst),
    .o_imm_form   (w_imm_form),
    .o_shift_op   (w_shift_op),
    .o_shift_num  (w_shift_num),
    .o_shift_data (w_shift_data)
  );

  assign In_Ready = (r_state == ST_IDLE) | ((r_state == ST_OUT) & Out_Ready);
  assign w_accept = In_Valid & In_Ready & ~Flush;

  // R15 reads see the pipelined PC; the offset depends on the operand form
  assign w_rm_val = (r_rm == R15) ? (r_pc + (r_reg_shift ? PC_OFS_REG : PC_OFS_IMM)) : R_Data;
  assign w_rs_val = (r_rs == R15) ? (r_pc + PC_OFS_REG) : R_Data;

  assign R_En       = (r_state == ST_RD_RM) | (r_state == ST_RD_RS);
  assign R_Addr     = (r_state == ST_RD_RM) ? r_rm :
                      (r_state == ST_RD_RS) ? r_rs : 4'd0;
  assign Out_Valid  = (r_state == ST_OUT);
  assign Shift_Data = r_shift_data;
  assign Shift_Num  = r_shift_num;
  assign SHIFT_OP   = r_shift_op;
  assign Carry_flag = r_carry;

  // Fetch FSM: accept, read Rm, optionally read Rs, then hold the bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rm         <= 4'd0;
      r_rs         <= 4'd0;
      r_reg_shift  <= 1'b0;
      r_pc         <= 32'd0;
      r_shift_data <= 32'd0;
      r_shift_num  <= 8'd0;
      r_shift_op   <= 3'd0;
      r_carry      <= 1'b0;
    end else if (Flush) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      r_rm         <= Inst[RM_MSB:RM_LSB];
      r_rs         <= Inst[RS_MSB:RS_LSB];
      r_reg_shift  <= Inst[RS_FLAG];
      r_pc         <= PC;
      r_carry      <= C_In;
      r_shift_op   <= w_shift_op;
      r_shift_num  <= w_shift_num;
      r_shift_data <= w_shift_data;
      r_state      <= w_imm_form ? ST_OUT : ST_RD_RM;
    end else begin
      case (r_state)
        ST_RD_RM: begin
          r_shift_data <= w_rm_val;
          r_state      <= r_reg_shift ? ST_RD_RS : ST_OUT;
        end
        ST_RD_RS: begin
          r_shift_num <= w_rs_val[7:0];
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (Out_Ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand2_fetch.sv
// Self-checking bench for operand2_fetch with a behavioural operand model.
module tb_operand2_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        In_Valid, In_Ready, C_In, Flush;
  logic [31:0] Inst, PC, R_Data;
  logic        R_En;
  logic [3:0]  R_Addr;
  logic        Out_Valid, Out_Ready, Carry_flag;
  logic [31:0] Shift_Data;
  logic [7:0]  Shift_Num;
  logic [2:0]  SHIFT_OP;

  logic [31:0] regs [16];
  int n_tests = 0;
  int n_fail  = 0;

  assign R_Data = regs[R_Addr];

  always #5 clk = ~clk;

  operand2_fetch #(.PC_OFS_IMM(32'd8), .PC_OFS_REG(32'd12)) dut (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(In_Ready), .Inst(Inst),
    .PC(PC), .C_In(C_In), .Flush(Flush), .R_En(R_En), .R_Addr(R_Addr),
    .R_Data(R_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .SHIFT_OP(SHIFT_OP),
    .Carry_flag(Carry_flag)
  );

  // Reference: what the shifter should receive for an instruction
  function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                output logic [31:0] d, output logic [7:0] n,
                                output logic [2:0] op, output int lat, output int nrd,
                                output logic [3:0] a0, output logic [3:0] a1);
    logic [3:0]  rm, rs;
    logic [31:0] rsv;
    rm = inst[3:0];
    rs = inst[11:8];
    a0 = rm;
    a1 = rs;
    if (inst[25]) begin
      d = 32'(inst[7:0]);
      n = 8'(inst[11:8] * 2);
      op = 3'b111;
      lat = 1;
      nrd = 0;
    end else begin
      if (rm == 4'd15) d = pc + (inst[4] ? 32'd12 : 32'd8);
      else d = regs[rm];
      op = {inst[6:5], inst[4]};
      if (inst[4]) begin
        rsv = (rs == 4'd15) ? pc + 32'd12 : regs[rs];
        n = rsv[7:0];
        lat = 3;
        nrd = 2;
      end else begin
        n = 8'(inst[11:7]);
        lat = 2;
        nrd = 1;
      end
    end
  endfunction

  // Offer one op from IDLE and watch it until Out_Valid (bounded)
  task automatic drive_op(input logic [31:0] inst, input logic [31:0] pc, input logic c,
                          output int lat, output int nrd, output logic [3:0] a0,
                          output logic [3:0] a1);
    @(negedge clk);
    In_Valid = 1'b1; Inst = inst; PC = pc; C_In = c; Out_Ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    In_Valid = 1'b0; Inst = $urandom; PC = $urandom; C_In = 1'($urandom_range(0, 1));
    lat = 99; nrd = 0; a0 = 4'd0; a1 = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (R_En) begin
        if (nrd == 0) a0 = R_Addr; else a1 = R_Addr;
        nrd++;
      end
      if (Out_Valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    Out_Ready = 1'b1;
    @(posedge clk);
    #1 Out_Ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({Out_Valid, R_En, R_Addr} !== 6'd0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0", {Out_Valid, R_En, R_Addr}); end
    n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} !== 44'd0) begin n_fail++; $display("FAIL reset_bundle got %h want 0", {Shift_Data, Shift_Num, SHIFT_OP, Carry_flag}); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (In_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", In_Ready); end
  endtask

  task automatic test_imm_rotate();
    int lat, nrd; logic [3:0] a0, a1;
    drive_op(32'hE3A014FF, 32'h0, 1'b1, lat, nrd, a0, a1);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL rot_latency got %0d want 1", lat); end
    n_tests++; if (nrd !== 0) begin n_fail++; $display("FAIL rot_reads got %0d want 0", nrd); end
    n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} !== {32'hFF, 8'd8, 3'b111, 1'b1}) begin n_fail++; $display("FAIL rot_bundle got %h/%h/%b/%b want ff/08/111/1", Shift_Data, Shift_Num, SHIFT_OP, Carry_flag); end
    consume();
  endtask

  task automatic test_imm_shift();
    int lat, nrd; logic [3:0] a0, a1;
    regs[2] = 32'h80000001;
    drive_op(32'hE1A01102, 32'h0, 1'b0, lat, nrd, a0, a1);
    n_tests++; if ({lat, nrd, a0} !== {32'd2, 32'd1, 4'd2}) begin n_fail++; $display("FAIL ishift_lat_reads got lat=%0d rd=%0d a0=%0d want 2/1/2", lat, nrd, a0); end
    n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP} !== {32'h80000001, 8'd2, 3'b000}) begin n_fail++; $display("FAIL ishift_bundle got %h/%h/%b want 80000001/02/000", Shift_Data, Shift_Num, SHIFT_OP); end
    consume();
    drive_op(32'hE1A0100F, 32'h100, 1'b0, lat, nrd, a0, a1);
    n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP} !== {32'h108, 8'd0, 3'b000}) begin n_fail++; $display("FAIL ishift_r15 got %h/%h/%b want 108/00/000", Shift_Data, Shift_Num, SHIFT_OP); end
    consume();
    drive_op(32'hE1A01022, 32'h0, 1'b1, lat, nrd, a0, a1);
    n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} !== {32'h80000001, 8'd0, 3'b010, 1'b1}) begin n_fail++; $display("FAIL ishift_lsr0 got %h/%h/%b/%b want 80000001/00/010/1", Shift_Data, Shift_Num, SHIFT_OP, Carry_flag); end
    consume();
  endtask

  task automatic test_reg_shift();
    int lat, nrd; logic [3:0] a0, a1;
    logic [44:0] held;
    regs[2] = 32'hF0000000;
    regs[3] = 32'h00000121;
    drive_op(32'hE1A01332, 32'h0, 1'b0, lat, nrd, a0, a1);
    n_tests++; if ({lat, nrd, a0, a1} !== {32'd3, 32'd2, 4'd2, 4'd3}) begin n_fail++; $display("FAIL rshift_lat_reads got lat=%0d rd=%0d a=%0d,%0d want 3/2/2,3", lat, nrd, a0, a1); end
    n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP} !== {32'hF0000000, 8'h21, 3'b011}) begin n_fail++; $display("FAIL rshift_bundle got %h/%h/%b want f0000000/21/011", Shift_Data, Shift_Num, SHIFT_OP); end
    held = {Out_Valid, In_Ready, Shift_Data, Shift_Num, SHIFT_OP};
    regs[2] = 32'h0; regs[3] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++; if ({Out_Valid, In_Ready, Shift_Data, Shift_Num, SHIFT_OP} !== {1'b1, 1'b0, 32'hF0000000, 8'h21, 3'b011}) begin n_fail++; $display("FAIL rshift_stall%0d got %h want %h", k, {Out_Valid, In_Ready, Shift_Data, Shift_Num, SHIFT_OP}, held); end
    end
    consume();
    @(negedge clk);
    n_tests++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL rshift_release got %b want 0", Out_Valid); end
  endtask

  task automatic test_random();
    int lat, nrd, elat, enrd; logic [3:0] a0, a1, ea0, ea1;
    logic [31:0] inst, pc, ed; logic [7:0] en; logic [2:0] eop; logic c;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 16; r++) regs[r] = $urandom;
      inst = $urandom; pc = $urandom; c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) inst[3:0] = 4'hF;
      if ($urandom_range(0, 3) == 0) inst[11:8] = 4'hF;
      model(inst, pc, ed, en, eop, elat, enrd, ea0, ea1);
      drive_op(inst, pc, c, lat, nrd, a0, a1);
      n_tests++; if ({lat, nrd} !== {elat, enrd}) begin n_fail++; $display("FAIL rnd%0d_timing inst=%h got lat=%0d rd=%0d want %0d/%0d", it, inst, lat, nrd, elat, enrd); end
      if (enrd > 0) begin n_tests++; if (a0 !== ea0) begin n_fail++; $display("FAIL rnd%0d_rm_addr got %0d want %0d", it, a0, ea0); end end
      if (enrd > 1) begin n_tests++; if (a1 !== ea1) begin n_fail++; $display("FAIL rnd%0d_rs_addr got %0d want %0d", it, a1, ea1); end end
      n_tests++; if ({Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} !== {ed, en, eop, c}) begin n_fail++; $display("FAIL rnd%0d_bundle inst=%h got %h/%h/%b/%b want %h/%h/%b/%b", it, inst, Shift_Data, Shift_Num, SHIFT_OP, Carry_flag, ed, en, eop, c); end
      consume();
    end
  endtask

  task automatic test_flush();
    regs[2] = 32'h1234; regs[3] = 32'h5;
    @(negedge clk);
    In_Valid = 1'b1; Inst = 32'hE1A01332; PC = 32'h0; Out_Ready = 1'b0;
    @(negedge clk);
    In_Valid = 1'b0;
    @(negedge clk);
    n_tests++; if ({R_En, R_Addr} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL flush_in_rs got %b/%0d want 1/3", R_En, R_Addr); end
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    n_tests++; if ({Out_Valid, In_Ready, R_En} !== 3'b010) begin n_fail++; $display("FAIL flush_rs got %b want 010", {Out_Valid, In_Ready, R_En}); end
    repeat (3) @(negedge clk);
    n_tests++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_stays_idle got %b want 0", Out_Valid); end
    // Flush beats a simultaneous offer
    In_Valid = 1'b1; Inst = 32'hE3A014FF; Flush = 1'b1;
    @(negedge clk);
    In_Valid = 1'b0; Flush = 1'b0;
    n_tests++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept got %b want 0", Out_Valid); end
    // Flush out of a stalled OUT
    In_Valid = 1'b1;
    @(negedge clk);
    In_Valid = 1'b0; Flush = 1'b1;
    n_tests++; if (Out_Valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_out got %b want 1", Out_Valid); end
    @(negedge clk);
    Flush = 1'b0;
    n_tests++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_out got %b want 0", Out_Valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    In_Valid = 1'b1; Inst = 32'hE1A01102; PC = 32'h40; C_In = 1'b1; Out_Ready = 1'b0;
    @(negedge clk);
    In_Valid = 1'b0;
    n_tests++; if ({R_En, R_Addr} !== {1'b1, 4'd2}) begin n_fail++; $display("FAIL arst_pre got %b/%0d want 1/2", R_En, R_Addr); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if ({Out_Valid, R_En, R_Addr, Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} !== 50'd0) begin n_fail++; $display("FAIL arst_immediate got %h want 0", {Out_Valid, R_En, R_Addr, Shift_Data, Shift_Num, SHIFT_OP, Carry_flag}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if ({Out_Valid, In_Ready} !== 2'b01) begin n_fail++; $display("FAIL arst_after got %b want 01", {Out_Valid, In_Ready}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    In_Valid = 1'b1; Inst = 32'hE3A014FF; C_In = 1'b1; Out_Ready = 1'b1;
    @(negedge clk);
    n_tests++; if ({Out_Valid, In_Ready, Shift_Data, Shift_Num, Carry_flag} !== {1'b1, 1'b1, 32'hFF, 8'd8, 1'b1}) begin n_fail++; $display("FAIL b2b_first got %b/%b/%h/%h/%b want 1/1/ff/08/1", Out_Valid, In_Ready, Shift_Data, Shift_Num, Carry_flag); end
    Inst = 32'hE3A02C3C; C_In = 1'b0;
    @(negedge clk);
    In_Valid = 1'b0;
    n_tests++; if ({Out_Valid, Shift_Data, Shift_Num, SHIFT_OP, Carry_flag} !== {1'b1, 32'h3C, 8'd24, 3'b111, 1'b0}) begin n_fail++; $display("FAIL b2b_second got %b/%h/%h/%b/%b want 1/3c/18/111/0", Out_Valid, Shift_Data, Shift_Num, SHIFT_OP, Carry_flag); end
    @(negedge clk);
    Out_Ready = 1'b0;
    n_tests++; if (Out_Valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", Out_Valid); end
  endtask

  initial begin
    In_Valid = 1'b0; Inst = 32'h0; PC = 32'h0; C_In = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
    for (int r = 0; r < 16; r++) regs[r] = 32'h0;
    test_reset();
    test_imm_rotate();
    test_imm_shift();
    test_reg_shift();
    test_random();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
